// File: rtl/second_phase_pkg.sv
// Shared definitions for the second-phase classifier ROM arbiter.
// Holds the default sizes, the stage one-hot type and the round-robin
// pointer increment helper that the arbiter and its picker use.
package second_phase_pkg;

    localparam int unsigned DEFAULT_NUM_STAGES    = 8;
    localparam int unsigned DEFAULT_INDEX_WIDTH   = 12;
    localparam int unsigned DEFAULT_DATA_WIDTH_12 = 12;
    localparam int unsigned DEFAULT_ROM_LATENCY   = 2;

    // One bit per requesting stage engine.
    typedef logic [DEFAULT_NUM_STAGES-1:0] stage_onehot_t;

    // Next round-robin position; wraps explicitly so non-power-of-2 counts work.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/second_phase_rr_picker.sv
// Combinational round-robin picker.
// Ports:
//   eligible     - per-stage candidates this cycle
//   ptr          - first index to consider; search wraps modulo NUM_STAGES
//   win_onehot_c - one-hot winner (all zero when nothing is eligible)
//   win_idx_c    - binary index of the winner
//   any_c        - at least one stage is eligible
module second_phase_rr_picker
    import second_phase_pkg::*;
#(
    parameter int unsigned NUM_STAGES = DEFAULT_NUM_STAGES,
    parameter int unsigned PTR_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic [NUM_STAGES-1:0] eligible,
    input  logic [PTR_W-1:0]      ptr,
    output logic [NUM_STAGES-1:0] win_onehot_c,
    output logic [PTR_W-1:0]      win_idx_c,
    output logic                  any_c
);

    // Scan from ptr upward, wrapping, and keep the first hit.
    always_comb begin : pick_comb
        int unsigned idx;
        idx          = 0;
        win_onehot_c = '0;
        win_idx_c    = '0;
        any_c        = 1'b0;
        for (int unsigned off = 0; off < NUM_STAGES; off++) begin
            idx = 32'(ptr) + off;
            if (idx >= NUM_STAGES) begin
                idx = idx - NUM_STAGES;
            end
            if (!any_c && eligible[PTR_W'(idx)]) begin
                any_c     = 1'b1;
                win_idx_c = PTR_W'(idx);
            end
        end
        if (any_c) begin
            win_onehot_c[win_idx_c] = 1'b1;
        end
    end

endmodule

// File: rtl/second_phase_rom_arbiter.sv
// Shares the classifier-database ROM between the second-phase stage engines.
// One requester is granted per cycle in round-robin order; the read is issued
// to the ROM and the returned word is routed back tagged by a one-hot valid.
// Ports:
//   clk_fpga, reset_fpga - clock, synchronous active-high reset
//   arb_enable           - 1 allows new grants, 0 only drains in-flight reads
//   req, req_index       - per-stage level request and packed ROM indices
//   gnt                  - one-hot grant pulse
//   rom_rd_en, rom_addr  - ROM read strobe and address
//   rom_data             - ROM word, valid ROM_LATENCY cycles after rom_rd_en
//   rsp_valid, rsp_data  - one-hot response pulse and response word
//   busy                 - grant, read or response still in flight
module second_phase_rom_arbiter
    import second_phase_pkg::*;
#(
    parameter int unsigned NUM_STAGES    = DEFAULT_NUM_STAGES,
    parameter int unsigned INDEX_WIDTH   = DEFAULT_INDEX_WIDTH,
    parameter int unsigned DATA_WIDTH_12 = DEFAULT_DATA_WIDTH_12,
    parameter int unsigned ROM_LATENCY   = DEFAULT_ROM_LATENCY
) (
    input  logic                          clk_fpga,
    input  logic                          reset_fpga,
    input  logic                          arb_enable,
    input  logic [NUM_STAGES-1:0]         req,
    input  logic [NUM_STAGES*INDEX_WIDTH-1:0] req_index,
    output logic [NUM_STAGES-1:0]         gnt,
    output logic                          rom_rd_en,
    output logic [INDEX_WIDTH-1:0]        rom_addr,
    input  logic [DATA_WIDTH_12-1:0]      rom_data,
    output logic [NUM_STAGES-1:0]         rsp_valid,
    output logic [DATA_WIDTH_12-1:0]      rsp_data,
    output logic                          busy
);

    localparam int unsigned PTR_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    typedef struct packed {
        logic                  valid;
        logic [NUM_STAGES-1:0] id;
    } tag_t;

    logic [PTR_W-1:0]       ptr_q;
    logic [NUM_STAGES-1:0]  eligible_c;
    logic [NUM_STAGES-1:0]  win_onehot_c;
    logic [PTR_W-1:0]       win_idx_c;
    logic                   win_any_c;
    logic [INDEX_WIDTH-1:0] win_index_c;
    logic                   tag_any_c;
    tag_t                   tag_q [ROM_LATENCY];

    // A stage holding gnt now is masked so it cannot win two cycles in a row.
    assign eligible_c = arb_enable ? (req & ~gnt) : '0;

    second_phase_rr_picker #(
        .NUM_STAGES (NUM_STAGES),
        .PTR_W      (PTR_W)
    ) u_picker (
        .eligible     (eligible_c),
        .ptr          (ptr_q),
        .win_onehot_c (win_onehot_c),
        .win_idx_c    (win_idx_c),
        .any_c        (win_any_c)
    );

    // Index of the winning stage.
    always_comb begin
        win_index_c = '0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            if (win_onehot_c[i]) begin
                win_index_c = req_index[i*INDEX_WIDTH +: INDEX_WIDTH];
            end
        end
    end

    // Any read still travelling through the ROM.
    always_comb begin
        tag_any_c = 1'b0;
        for (int unsigned i = 0; i < ROM_LATENCY; i++) begin
            tag_any_c = tag_any_c | tag_q[i].valid;
        end
    end

    // Grant/issue registers, tag pipeline aligned to rom_data, response capture.
    always_ff @(posedge clk_fpga) begin
        if (reset_fpga) begin
            gnt       <= '0;
            rom_rd_en <= 1'b0;
            rom_addr  <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            busy      <= 1'b0;
            ptr_q     <= '0;
            for (int unsigned i = 0; i < ROM_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            gnt       <= win_onehot_c;
            rom_rd_en <= win_any_c;
            if (win_any_c) begin
                rom_addr <= win_index_c;
                ptr_q    <= PTR_W'(rr_next(32'(win_idx_c), NUM_STAGES));
            end

            tag_q[0] <= '{valid: rom_rd_en, id: gnt};
            for (int unsigned i = 1; i < ROM_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end

            // Last tag stage lines up with the cycle rom_data is valid.
            rsp_valid <= tag_q[ROM_LATENCY-1].valid ? tag_q[ROM_LATENCY-1].id : '0;
            if (tag_q[ROM_LATENCY-1].valid) begin
                rsp_data <= rom_data;
            end

            // Next-cycle view of rom_rd_en | tags | rsp_valid.
            busy <= win_any_c | rom_rd_en | tag_any_c;
        end
    end

endmodule
